// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Optional feature macro: SEG_SCAN_PWM_EN (adds per-slot anode PWM dimming).
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  // Formatter text codes.
  localparam logic [7:0] CODE_S     = 8'h0A;
  localparam logic [7:0] CODE_R     = 8'h0B;
  localparam logic [7:0] CODE_C     = 8'h0C;
  localparam logic [7:0] CODE_E     = 8'h0E;
  localparam logic [7:0] CODE_DASH  = 8'hFE;
  localparam logic [7:0] CODE_BLANK = 8'hFF;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_S    = 7'h12;
  localparam logic [6:0] SEG_R    = 7'h2F;
  localparam logic [6:0] SEG_C    = 7'h46;
  localparam logic [6:0] SEG_E    = 7'h06;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [7:0] ALL_AN_OFF = 8'hFF;

  // One-hot-low anode vector for a digit index.
  function automatic logic [7:0] an_onehot(input logic [2:0] sel);
    return ~(8'h01 << sel);
  endfunction

endpackage

// File: rtl/seg_scan_driver_decode.sv
// Combinational digit-code to active-low segment pattern decoder.
// Optional feature macro: SEG_SCAN_PWM_EN (no effect on this block).
module seg_decode
  import seg_scan_pkg::*;
(
  input  logic [7:0] digit_code,
  output logic [6:0] seg_pattern
);

  // Map each formatter code to its cathode pattern; unknown codes stay dark.
  always_comb begin
    // NOTE: every path assigns seg_pattern (default arm below), so no latch is inferred.
    unique case (digit_code)
      8'h00:      seg_pattern = SEG_0;
      8'h01:      seg_pattern = SEG_1;
      8'h02:      seg_pattern = SEG_2;
      8'h03:      seg_pattern = SEG_3;
      8'h04:      seg_pattern = SEG_4;
      8'h05:      seg_pattern = SEG_5;
      8'h06:      seg_pattern = SEG_6;
      8'h07:      seg_pattern = SEG_7;
      8'h08:      seg_pattern = SEG_8;
      8'h09:      seg_pattern = SEG_9;
      CODE_S:     seg_pattern = SEG_S;
      CODE_R:     seg_pattern = SEG_R;
      CODE_C:     seg_pattern = SEG_C;
      CODE_E:     seg_pattern = SEG_E;
      CODE_DASH:  seg_pattern = SEG_DASH;
      CODE_BLANK: seg_pattern = SEG_OFF;
      default:    seg_pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment scan driver.
// Each slot is BLANK_CYCLES dark cycles followed by the lit digit; all outputs
// are registered. Optional feature macro: SEG_SCAN_PWM_EN adds a brightness
// input that shortens the lit portion of each slot.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
`ifdef SEG_SCAN_PWM_EN
  input  logic [1:0] brightness,
`endif
  input  logic [7:0] digit_code,
  output logic [2:0] digit_sel,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`ifdef SEG_SCAN_PWM_EN
  localparam int SHOW_LEN = TICK_DIV - BLANK_CYCLES;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;
  logic             lit;
  logic [6:0]       seg_pattern;

  seg_decode u_decode (
    .digit_code  (digit_code),
    .seg_pattern (seg_pattern)
  );

`ifdef SEG_SCAN_PWM_EN
  logic [1:0] bright_q, bright_d;
  int         lit_len;

  // Brightness is latched at the BLANK->SHOW edge and sets the lit window length.
  always_comb begin
    bright_d = bright_q;
    if (state_q == BLANK && state_d == SHOW) bright_d = brightness;
    lit_len = ((int'(bright_d) + 1) * SHOW_LEN) / 4;
    lit     = (state_d == SHOW) && (int'(cnt_d) < BLANK_CYCLES + lit_len);
  end

  // Brightness sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bright_q <= 2'd0;
    else        bright_q <= bright_d;
  end
`else
  // Anodes are driven for the whole SHOW phase.
  always_comb lit = (state_d == SHOW);
`endif

  // Next-state logic: slot counter, digit index, captured pattern and frame strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    seg_d   = seg_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = 3'd0;
      seg_d   = SEG_OFF;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          sel_d   = 3'd0;
          seg_d   = SEG_OFF;
        end
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_BLANK_LAST) begin
            // Formatter output has settled; capture it for the whole SHOW phase.
            state_d = SHOW;
            seg_d   = seg_pattern;
          end
        end
        SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            sel_d   = sel_q + 3'd1;
            seg_d   = SEG_OFF;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = 3'd0;
          seg_d   = SEG_OFF;
        end
      endcase
    end
    // Registered strobe: high while the next cycle is the final cycle of slot 7.
    frame_done_d = (state_d == SHOW) && (sel_d == 3'd7) && (cnt_d == CNT_LAST);
    an_d         = lit ? an_onehot(sel_d) : ALL_AN_OFF;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= 3'd0;
      seg_q        <= SEG_OFF;
      an_q         <= ALL_AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit_sel  = sel_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule
